// File: rtl/feed_mux_pkg.sv
`default_nettype none
// ============================================================================
// Package     : feed_mux_pkg
// Description : Shared types and helpers for the feed stream multiplexer:
//               FSM state encoding, arbitration mode constants and the
//               round-robin picker function.
// Revision    : 1.0 - initial release
// ============================================================================
package feed_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // The picker always works on a 16-wide request vector. Unused upper
  // requests are zero, so wrapping modulo 16 visits the live channels in
  // exactly the same order as wrapping modulo the real channel count.
  localparam int PICK_N = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First requester at or after ptr, wrapping. Fixed priority is ptr=0.
  function automatic pick_t rr_pick(input logic [PICK_N-1:0] req,
                                    input logic [3:0]        ptr);
    pick_t      r;
    logic [3:0] k;
    r = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = PICK_N - 1; i >= 0; i--) begin
      k = ptr + 4'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feed_stream_mux_if.sv
`default_nettype none
// ============================================================================
// Interface   : feed_stream_mux_if
// Description : Bundles the per-channel Avalon-ST inputs and the merged
//               Avalon-ST output of the feed stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
interface feed_stream_mux_if #(
  parameter int C_NUM_CH         = 4,
  parameter int C_PKT_BEAT_BYTES = 8
);
  localparam int W      = C_PKT_BEAT_BYTES * 8;
  localparam int E      = $clog2(C_PKT_BEAT_BYTES);
  localparam int C_CH_W = (C_NUM_CH > 2) ? $clog2(C_NUM_CH) : 1;

  logic [C_NUM_CH-1:0]   in_valid;
  logic [C_NUM_CH-1:0]   in_ready;
  logic [C_NUM_CH-1:0]   in_startofpacket;
  logic [C_NUM_CH-1:0]   in_endofpacket;
  logic [C_NUM_CH*W-1:0] in_data;
  logic [C_NUM_CH*E-1:0] in_empty;
  logic [C_NUM_CH-1:0]   in_error;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_startofpacket;
  logic                  out_endofpacket;
  logic                  out_error;
  logic [W-1:0]          out_data;
  logic [E-1:0]          out_empty;
  logic [C_CH_W-1:0]     out_channel;

  // Feed decoders plus strategy side, seen from outside the mux.
  modport master (
    output in_valid, in_startofpacket, in_endofpacket, in_data, in_empty,
           in_error, out_ready,
    input  in_ready, out_valid, out_startofpacket, out_endofpacket,
           out_error, out_data, out_empty, out_channel
  );

  // The mux itself.
  modport slave (
    input  in_valid, in_startofpacket, in_endofpacket, in_data, in_empty,
           in_error, out_ready,
    output in_ready, out_valid, out_startofpacket, out_endofpacket,
           out_error, out_data, out_empty, out_channel
  );
endinterface
`default_nettype wire

// File: rtl/feed_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : feed_mux_arb
// Description : Combinational channel picker. Round-robin starting at the
//               supplied pointer, or fixed priority with lowest index first.
// Revision    : 1.0 - initial release
// ============================================================================
module feed_mux_arb
  import feed_mux_pkg::*;
#(
  parameter  int C_NUM_CH   = 4,
  parameter  int C_ARB_MODE = ARB_RR,
  localparam int C_CH_W     = (C_NUM_CH > 2) ? $clog2(C_NUM_CH) : 1
) (
  input  logic [C_NUM_CH-1:0] req_i,
  input  logic [C_CH_W-1:0]   ptr_i,
  output logic                found_o,
  output logic [C_CH_W-1:0]   idx_o
);

  logic [PICK_N-1:0] req_ext;
  logic [3:0]        ptr_ext;
  pick_t             pick;

  assign req_ext = PICK_N'(req_i);
  // Fixed priority is simply a round-robin search that always starts at 0.
  assign ptr_ext = (C_ARB_MODE == ARB_FIXED) ? 4'd0 : 4'(ptr_i);

  // Search the request vector for the next winner.
  always_comb begin
    pick = rr_pick(req_ext, ptr_ext);
  end

  assign found_o = pick.found;
  assign idx_o   = C_CH_W'(pick.idx);

endmodule
`default_nettype wire

// File: rtl/feed_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : feed_stream_mux
// Description : Packet-locked Avalon-ST multiplexer merging per-channel feed
//               decoder streams into one tagged stream. Stalled packets are
//               closed with a synthetic error EOP; orphan beats are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module feed_stream_mux
  import feed_mux_pkg::*;
#(
  parameter int C_NUM_CH         = 4,
  parameter int C_PKT_BEAT_BYTES = 8,
  parameter int C_ARB_MODE       = ARB_RR,
  parameter int C_TIMEOUT        = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  feed_stream_mux_if.slave        bus,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             timeout_cnt
);

  localparam int W      = C_PKT_BEAT_BYTES * 8;
  localparam int E      = $clog2(C_PKT_BEAT_BYTES);
  localparam int C_CH_W = (C_NUM_CH > 2) ? $clog2(C_NUM_CH) : 1;
  localparam int TO_W   = $clog2(C_TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(C_TIMEOUT - 1);
  localparam logic [C_CH_W-1:0] CH_LAST = C_CH_W'(C_NUM_CH - 1);

  state_t              state_q;
  logic [C_CH_W-1:0]   grant_q;
  logic [C_CH_W-1:0]   rr_ptr_q;
  logic [TO_W-1:0]     idle_q;
  logic [15:0]         drop_q;
  logic [15:0]         to_q;

  logic                out_valid_q;
  logic                out_sop_q;
  logic                out_eop_q;
  logic                out_err_q;
  logic [W-1:0]        out_data_q;
  logic [E-1:0]        out_empty_q;
  logic [C_CH_W-1:0]   out_ch_q;

  logic                adv;
  logic [C_NUM_CH-1:0] cand;
  logic [C_NUM_CH-1:0] orphan;
  logic [C_NUM_CH-1:0] grant_oh;
  logic [C_NUM_CH-1:0] in_ready_w;
  logic                arb_found;
  logic [C_CH_W-1:0]   arb_idx;
  logic [C_CH_W-1:0]   rr_next;
  logic [4:0]          orphan_n;
  logic [16:0]         drop_sum;
  logic [15:0]         drop_d;
  logic [15:0]         to_d;

  logic                g_valid;
  logic                g_sop;
  logic                g_eop;
  logic                g_err;
  logic [W-1:0]        g_data;
  logic [E-1:0]        g_empty;

  // Output register may take a new beat when empty or being drained.
  assign adv      = !out_valid_q || bus.out_ready;
  assign cand     = bus.in_valid & bus.in_startofpacket;
  assign orphan   = bus.in_valid & ~bus.in_startofpacket;
  assign grant_oh = {{(C_NUM_CH-1){1'b0}}, 1'b1} << grant_q;
  assign rr_next  = (grant_q == CH_LAST) ? '0 : grant_q + 1'b1;

  // Fields of the currently granted channel.
  assign g_valid = bus.in_valid[grant_q];
  assign g_sop   = bus.in_startofpacket[grant_q];
  assign g_eop   = bus.in_endofpacket[grant_q];
  assign g_err   = bus.in_error[grant_q];
  assign g_data  = bus.in_data[int'(grant_q)*W +: W];
  assign g_empty = bus.in_empty[int'(grant_q)*E +: E];

  feed_mux_arb #(
    .C_NUM_CH   (C_NUM_CH),
    .C_ARB_MODE (C_ARB_MODE)
  ) u_arb (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // Count orphans this cycle and form saturated counter updates.
  always_comb begin
    orphan_n = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      orphan_n = orphan_n + 5'(orphan[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(orphan_n);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    to_d     = (to_q == 16'hFFFF) ? to_q : to_q + 16'd1;
  end

  // Per-channel accept: orphans while idle, the granted channel otherwise.
  always_comb begin
    in_ready_w = '0;
    case (state_q)
      IDLE:    in_ready_w = orphan;
      LOCK:    in_ready_w = adv ? grant_oh : '0;
      FLUSH:   in_ready_w = grant_oh;
      default: in_ready_w = '0;
    endcase
  end

  // Reset forces every output low straight away, including the accepts.
  assign bus.in_ready = reset_n ? in_ready_w : '0;

  // Arbitration FSM, output register, idle timer and status counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      idle_q      <= '0;
      drop_q      <= '0;
      to_q        <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      out_empty_q <= '0;
      out_ch_q    <= '0;
    end else begin
      // A drained beat retires unless a new one is loaded below.
      if (adv) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (|orphan) begin
            drop_q <= drop_d;
          end
          if (arb_found) begin
            grant_q <= arb_idx;
            idle_q  <= '0;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (g_valid) begin
            // A real beat always beats the timer, even on the expiry cycle.
            idle_q <= '0;
            if (adv) begin
              out_valid_q <= 1'b1;
              out_sop_q   <= g_sop;
              out_eop_q   <= g_eop;
              out_err_q   <= g_err;
              out_data_q  <= g_data;
              out_empty_q <= g_empty;
              out_ch_q    <= grant_q;
              if (g_eop) begin
                rr_ptr_q <= rr_next;
                state_q  <= IDLE;
              end
            end
          end else if (idle_q == TO_LAST) begin
            // Expired: close the packet once the output register is free.
            if (adv) begin
              out_valid_q <= 1'b1;
              out_sop_q   <= 1'b0;
              out_eop_q   <= 1'b1;
              out_err_q   <= 1'b1;
              out_data_q  <= '0;
              out_empty_q <= '0;
              out_ch_q    <= grant_q;
              to_q        <= to_d;
              state_q     <= FLUSH;
            end
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        FLUSH: begin
          if (g_valid) begin
            if (g_eop) begin
              rr_ptr_q <= rr_next;
              state_q  <= IDLE;
            end else if (g_sop) begin
              // A fresh packet start ends the flush but is itself lost.
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.out_startofpacket = out_sop_q;
  assign bus.out_endofpacket   = out_eop_q;
  assign bus.out_error         = out_err_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_empty         = out_empty_q;
  assign bus.out_channel       = out_ch_q;
  assign drop_cnt              = drop_q;
  assign timeout_cnt           = to_q;

endmodule
`default_nettype wire

// File: doc/feed_stream_mux.md
# feed_stream_mux

Multi-channel Avalon-ST packet multiplexer between up to C_NUM_CH feed decoders and the strategy decoder interface. It merges per-channel decoded streams into one output stream with packet-locked arbitration (round-robin or fixed priority), and tags every beat with its source channel. It terminates stalled packets with an error beat, and discards orphan beats that arrive outside a packet.

## Interface
- C_NUM_CH, 4: input channel count, 2..16.
- C_PKT_BEAT_BYTES, 8: bytes per beat.
  - Data width W = C_PKT_BEAT_BYTES*8.
  - Empty width E = $clog2(C_PKT_BEAT_BYTES).
- C_ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- C_TIMEOUT, 256: idle cycles tolerated mid-packet on the granted channel, ≥2.
- C_CH_W: localparam, max(1, $clog2(C_NUM_CH)).
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: core clock.
  - reset_n, in, 1: asynchronous active-low reset.
- Input ports, one bit or field per channel; channel g occupies bit g or slice g:
  - in_valid, in, C_NUM_CH: per-channel beat valid.
  - in_ready, out, C_NUM_CH: per-channel accept.
  - in_startofpacket, in, C_NUM_CH: per-channel SOP.
  - in_endofpacket, in, C_NUM_CH: per-channel EOP.
  - in_data, in, C_NUM_CH*W: channel g at [g*W +: W].
  - in_empty, in, C_NUM_CH*E: channel g at [g*E +: E].
  - in_error, in, C_NUM_CH: per-channel error.
- Output ports:
  - out_valid, out_startofpacket, out_endofpacket, out_error, out, 1 each: registered.
  - out_ready, in, 1: downstream accept.
  - out_data, out, W; out_empty, out, E: registered.
  - out_channel, out, C_CH_W: source channel of the current beat.
  - drop_cnt, out, 16: saturating count of discarded beats.
  - timeout_cnt, out, 16: saturating count of forced terminations.

## Operation
- FSM states:
  - IDLE: no channel granted.
  - LOCK: granted channel g streams its packet.
  - FLUSH: channel g is drained after a timeout.
- Output register:
  - The register advances when !out_valid || out_ready, abbreviated adv.
  - in_ready[g] = (state==LOCK) && (g==grant) && adv.
- IDLE:
  - Candidates are channels with in_valid && in_startofpacket.
  - Round-robin: search starts at rr_ptr and wraps modulo C_NUM_CH. Fixed priority: lowest index wins.
  - With a candidate: register grant and go to LOCK. No beat is accepted in this cycle.
  - A channel with in_valid && !in_startofpacket is an orphan. Assert in_ready for it, discard the beat, and increment drop_cnt. Several orphans in one cycle add their count to drop_cnt.
- LOCK:
  - Each handshake on channel g loads the output register with that beat and sets out_channel=g.
  - A handshake with EOP goes to IDLE and sets rr_ptr=(g+1) mod C_NUM_CH.
  - A second SOP on g inside the packet is passed through unchanged; no checking.
  - Other channels see in_ready=0.
- Timeout:
  - idle_ctr counts cycles in LOCK where in_valid[g]=0. It clears on any in_valid[g]=1 and on entry to LOCK.
  - On reaching C_TIMEOUT-1 with adv=1:
    - Load a synthetic beat: valid=1, eop=1, error=1, sop=0, data=0, empty=0, channel=g.
    - Increment timeout_cnt and go to FLUSH.
  - If adv=0 at that point, hold the counter until adv=1.
  - If in_valid[g] rises in the same cycle as expiry, the real beat wins and the counter clears.
- FLUSH:
  - in_ready[g]=1 and beats are discarded without incrementing drop_cnt.
  - A beat with EOP goes to IDLE. rr_ptr advances as in LOCK.
  - A beat with SOP and no EOP also returns to IDLE but is discarded.
- Counters saturate at 16'hFFFF.
- Reset:
  - All outputs are 0; state=IDLE, rr_ptr=0, grant=0, counters=0.
  - An asserted reset mid-packet drops the packet. No EOP is emitted.

## Timing
- An SOP presented at cycle 0 on an idle mux is granted at cycle 0. It is accepted at cycle 1 and appears on out_* at cycle 2.
- Throughput inside a packet is 1 beat/cycle while out_ready=1.
- There is one bubble cycle between consecutive packets (IDLE arbitration).
- Backpressure: out_ready=0 with out_valid=1 holds all out_* stable. in_ready drops in the same cycle.
- The synthetic EOP appears one cycle after expiry.

## Structure
- Package feed_mux_pkg holds:
  - The state_t enum (IDLE, LOCK, FLUSH).
  - Arbitration mode constants ARB_RR=0, ARB_FIXED=1.
  - The function rr_pick(req, ptr) returning index and found.
- One sub-module, feed_mux_arb: combinational round-robin/priority picker parametrised by C_NUM_CH and C_ARB_MODE.
- The FSM, output register and counters live in feed_stream_mux.

## Test plan
- Round-robin fairness: C_NUM_CH=4, all channels continuously send 3-beat packets, out_ready=1. Required response:
  - out_channel order is 0,1,2,3,0.
  - Each packet is contiguous.
  - One idle cycle between packets.
- Fixed priority: C_ARB_MODE=1, channels 1 and 3 request simultaneously. Required response:
  - Channel 1's packet is emitted first, then channel 3's.
  - No interleaving.
- Backpressure: out_ready toggles 1,0,0,1 during a 5-beat packet on ch2. Required response:
  - Data is emitted in order with no loss or duplication.
  - out_* are stable while out_ready=0.
- Timeout: C_TIMEOUT=8, ch0 sends SOP plus 1 beat, then goes silent 8 cycles, then sends 2 beats with the last EOP. Required response:
  - Synthetic beat with eop=1, error=1, data=0 is emitted.
  - timeout_cnt=1.
  - The 2 late beats are discarded; drop_cnt=0.
- Orphans: ch1 sends 3 beats with sop=0 while idle. Required response:
  - drop_cnt=3, no output.
  - A next SOP packet on ch1 is emitted normally.
- Reset mid-packet: assert reset_n=0 at beat 2 of 4. Required response:
  - All outputs are 0 immediately.
  - After release, a new packet is accepted starting with rr_ptr=0.
